pipeline_run_controller: RTL and testbench
==========================================

Name: pipeline_run_controller

Overview:
Execution sequencer for the 5-stage MIPS pipeline. Accepts byte commands from the debug link, gates the global pipeline enable for continuous or single-step runs, and drains the pipeline once HALT is decoded. After each run or step it streams a state dump to the link transmitter through a valid/ready handshake: PC, cycle count, register file, then data memory.

Parameters:
NB_DATA, 32, width of PC, cycle counter, register and memory words
NB_CMD, 8, command byte width
N_REGS, 32, registers dumped
NB_REG_ADDR, 5, register file read address width
N_MEM_WORDS, 32, data memory words dumped
NB_MEM_ADDR, 5, data memory word address width
DRAIN_CYCLES, 3, extra enabled cycles after HALT seen in ID so older instructions retire
MAX_RUN_CYCLES, 1024, watchdog limit (optional feature only)

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_cmd_valid  in  1  command byte available
i_cmd  in  NB_CMD  command: 0x43 'C' run, 0x53 'S' step, 0x44 'D' dump
o_cmd_ready  out  1  command accepted this cycle when high with i_cmd_valid
i_halt  in  1  HALT opcode present in ID stage
i_pc  in  NB_DATA  current IF program counter
o_pipe_enable  out  1  global pipeline enable
o_rf_rd_addr  out  NB_REG_ADDR  debug read port address, register file
i_rf_rd_data  in  NB_DATA  register file data, 1-cycle latency
o_mem_rd_addr  out  NB_MEM_ADDR  debug read port address, data memory
i_mem_rd_data  in  NB_DATA  memory data, 1-cycle latency
o_tx_valid  out  1  dump word valid
o_tx_data  out  NB_DATA  dump word
i_tx_ready  in  1  transmitter accepts word
o_halted  out  1  program reached HALT, sticky
o_busy  out  1  high in any state other than IDLE/DONE
o_timeout  out  1  watchdog fired, sticky (0 when feature absent)

Behaviour:
- All outputs are registered. Reset value of every output and counter is 0. State resets to IDLE. o_cmd_ready rises on the first edge after reset release.
- States: IDLE, RUN, STEP, DRAIN, DUMP_PC, DUMP_CYC, DUMP_REG, DUMP_MEM, DONE.
- IDLE: o_cmd_ready=1. On a handshake:
  - 'C' -> RUN
  - 'S' -> STEP
  - 'D' -> DUMP_PC
  - any other byte is consumed and ignored
  - o_cmd_ready drops the cycle after a handshake.
- RUN: o_pipe_enable=1, cycle counter +1 per cycle. i_halt=1 -> DRAIN, load drain counter with DRAIN_CYCLES.
- DRAIN: o_pipe_enable=1, counter +1 per cycle, drain counter decrements. At 0: o_pipe_enable=0, o_halted=1, -> DUMP_PC.
- STEP: exactly one cycle with o_pipe_enable=1, counter +1. If i_halt is seen that cycle -> DRAIN; else -> DUMP_PC.
- Dump word sequence: PC snapshot (latched on DUMP_PC entry), cycle counter, regs 0..N_REGS-1, mem 0..N_MEM_WORDS-1. Total N_REGS+N_MEM_WORDS+2 words.
- Per reg/mem word:
  - drive address
  - capture read data one cycle later
  - assert o_tx_valid with o_tx_data stable until i_tx_ready
  - advance the address on the handshake cycle.
- o_tx_valid must never drop without a handshake.
- End of dump -> DONE if o_halted, else IDLE.
- DONE: o_cmd_ready=1. 'D' re-dumps and returns to DONE. 'C', 'S' and other bytes are consumed and ignored; only reset restarts execution.
- o_pipe_enable is 0 in every state except RUN, STEP and DRAIN.
- Cycle counter is NB_DATA bits and wraps from all-ones to 0. It is not cleared between runs.
- i_cmd_valid outside IDLE/DONE is not accepted: o_cmd_ready=0 and the byte stays pending.
- i_halt is ignored outside RUN and STEP.
- Reset mid-run or mid-dump: async clear. The in-flight dump word is dropped and o_tx_valid falls immediately.

Optional Feature:
PIPE_RUN_WATCHDOG_EN:
- Defined: a run counter clears on RUN entry and increments per RUN cycle. Reaching MAX_RUN_CYCLES without i_halt -> DRAIN, with o_timeout=1 (sticky) and o_halted=1.
- Not defined: RUN is unbounded; o_timeout is tied to 0.

Test Plan:
- Reset release, send 'D' with i_tx_ready=1 -> 66 words out: PC=0, cycle=0, then regs 0..31, then mem 0..31 matching the memory model; ends in IDLE.
- 'S' three times -> exactly one o_pipe_enable pulse per command; the cycle word in successive dumps reads 1, 2, 3.
- 'C' with i_halt raised 10 cycles after entry -> o_pipe_enable high 10+3 cycles, o_halted=1, cycle word=13, final state DONE, a later 'C' yields no enable pulse.
- i_tx_ready toggling 0/1 randomly during a dump -> o_tx_data stable while stalled, no word lost or duplicated, order preserved.
- Cycle counter preloaded to 0xFFFFFFFF, 'S' -> cycle word 0x00000000.
- i_reset low during DUMP_REG word 7 -> o_tx_valid=0 and o_pipe_enable=0 immediately; after release a 'D' dump starts from PC.

Source files
------------

// File: rtl/pipeline_run_controller.sv
// pipeline_run_controller: execution sequencer for the 5-stage MIPS pipeline.
// Takes byte commands from the debug link ('C' run, 'S' step, 'D' dump) and
// gates the global pipeline enable. Once HALT reaches ID it drains the
// pipeline. After each run or step it streams PC, cycle count, register file
// and data memory to the link transmitter.
// Optional watchdog: define PIPE_RUN_WATCHDOG_EN to bound RUN at MAX_RUN_CYCLES.
//
// state      | meaning
// IDLE       | waiting for a command, o_cmd_ready high
// RUN        | pipeline enabled until HALT is seen in ID
// STEP       | single enabled cycle
// DRAIN      | DRAIN_CYCLES extra enabled cycles so older instructions retire
// DUMP_PC    | sending the PC snapshot taken on entry
// DUMP_CYC   | sending the cycle counter
// DUMP_REG   | reading and sending registers 0..N_REGS-1
// DUMP_MEM   | reading and sending memory words 0..N_MEM_WORDS-1
// DONE       | program halted; only 'D' is honoured until reset
module pipeline_run_controller #(
   parameter int NB_DATA        = 32,
   parameter int NB_CMD         = 8,
   parameter int N_REGS         = 32,
   parameter int NB_REG_ADDR    = 5,
   parameter int N_MEM_WORDS    = 32,
   parameter int NB_MEM_ADDR    = 5,
   parameter int DRAIN_CYCLES   = 3,
   parameter int MAX_RUN_CYCLES = 1024
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_cmd_valid,
   input  logic [NB_CMD-1:0]      i_cmd,
   output logic                   o_cmd_ready,
   input  logic                   i_halt,
   input  logic [NB_DATA-1:0]     i_pc,
   output logic                   o_pipe_enable,
   output logic [NB_REG_ADDR-1:0] o_rf_rd_addr,
   input  logic [NB_DATA-1:0]     i_rf_rd_data,
   output logic [NB_MEM_ADDR-1:0] o_mem_rd_addr,
   input  logic [NB_DATA-1:0]     i_mem_rd_data,
   output logic                   o_tx_valid,
   output logic [NB_DATA-1:0]     o_tx_data,
   input  logic                   i_tx_ready,
   output logic                   o_halted,
   output logic                   o_busy,
   output logic                   o_timeout
);

   localparam logic [NB_CMD-1:0]      CMD_RUN    = NB_CMD'('h43);
   localparam logic [NB_CMD-1:0]      CMD_STEP   = NB_CMD'('h53);
   localparam logic [NB_CMD-1:0]      CMD_DUMP   = NB_CMD'('h44);
   localparam logic [7:0]             DRAIN_LOAD = 8'(DRAIN_CYCLES);
   localparam logic [NB_REG_ADDR-1:0] LAST_REG   = NB_REG_ADDR'(N_REGS - 1);
   localparam logic [NB_MEM_ADDR-1:0] LAST_MEM   = NB_MEM_ADDR'(N_MEM_WORDS - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_RUN, S_STEP, S_DRAIN, S_DUMP_PC, S_DUMP_CYC, S_DUMP_REG, S_DUMP_MEM, S_DONE
   } state_t;

   // ph: 0 = address on the port, 1 = read data arrives, 2 = word offered on tx
   state_t                 state_q, state_d;
   logic [NB_DATA-1:0]     cyc_q, cyc_d;
   logic [7:0]             drain_q, drain_d;
   logic [1:0]             ph_q, ph_d;
   logic                   tx_valid_d, halted_d, timeout_d;
   logic [NB_DATA-1:0]     tx_data_d;
   logic [NB_REG_ADDR-1:0] rf_addr_d;
   logic [NB_MEM_ADDR-1:0] mem_addr_d;
   logic                   cmd_hs, tx_hs;
`ifdef PIPE_RUN_WATCHDOG_EN
   logic [31:0]            run_q, run_d;
`endif

   assign cmd_hs = i_cmd_valid && o_cmd_ready;
   assign tx_hs  = o_tx_valid && i_tx_ready;

   // Next-state and next-output decode; every output is registered from here.
   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      drain_d    = drain_q;
      ph_d       = ph_q;
      tx_valid_d = o_tx_valid;
      tx_data_d  = o_tx_data;
      rf_addr_d  = o_rf_rd_addr;
      mem_addr_d = o_mem_rd_addr;
      halted_d   = o_halted;
      timeout_d  = o_timeout;
`ifdef PIPE_RUN_WATCHDOG_EN
      run_d      = run_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (cmd_hs) begin
               if (i_cmd == CMD_DUMP) begin
                  state_d = S_DUMP_PC;
               end else if (state_q == S_IDLE && i_cmd == CMD_RUN) begin
                  state_d = S_RUN;
`ifdef PIPE_RUN_WATCHDOG_EN
                  run_d   = '0;
`endif
               end else if (state_q == S_IDLE && i_cmd == CMD_STEP) begin
                  state_d = S_STEP;
               end
            end
         end
         S_RUN: begin
            cyc_d = cyc_q + NB_DATA'(1);
`ifdef PIPE_RUN_WATCHDOG_EN
            run_d = run_q + 32'd1;
`endif
            if (i_halt) begin
               state_d = S_DRAIN;
               drain_d = DRAIN_LOAD;
            end
`ifdef PIPE_RUN_WATCHDOG_EN
            else if (run_q == 32'(MAX_RUN_CYCLES - 1)) begin
               state_d   = S_DRAIN;
               drain_d   = DRAIN_LOAD;
               timeout_d = 1'b1;
            end
`endif
         end
         S_STEP: begin
            cyc_d = cyc_q + NB_DATA'(1);
            if (i_halt) begin
               state_d = S_DRAIN;
               drain_d = DRAIN_LOAD;
            end else begin
               state_d = S_DUMP_PC;
            end
         end
         S_DRAIN: begin
            cyc_d   = cyc_q + NB_DATA'(1);
            drain_d = drain_q - 8'd1;
            if (drain_q <= 8'd1) begin
               state_d  = S_DUMP_PC;
               halted_d = 1'b1;
            end
         end
         S_DUMP_PC: begin
            if (tx_hs) begin
               state_d   = S_DUMP_CYC;
               tx_data_d = cyc_q;
            end
         end
         S_DUMP_CYC: begin
            if (tx_hs) begin
               state_d    = S_DUMP_REG;
               tx_valid_d = 1'b0;
               rf_addr_d  = '0;
               ph_d       = 2'd0;
            end
         end
         S_DUMP_REG: begin
            if (ph_q == 2'd0) begin
               ph_d = 2'd1;
            end else if (ph_q == 2'd1) begin
               tx_data_d  = i_rf_rd_data;
               tx_valid_d = 1'b1;
               ph_d       = 2'd2;
            end else if (tx_hs) begin
               tx_valid_d = 1'b0;
               ph_d       = 2'd0;
               if (o_rf_rd_addr == LAST_REG) begin
                  state_d    = S_DUMP_MEM;
                  rf_addr_d  = '0;
                  mem_addr_d = '0;
               end else begin
                  rf_addr_d = o_rf_rd_addr + NB_REG_ADDR'(1);
               end
            end
         end
         S_DUMP_MEM: begin
            if (ph_q == 2'd0) begin
               ph_d = 2'd1;
            end else if (ph_q == 2'd1) begin
               tx_data_d  = i_mem_rd_data;
               tx_valid_d = 1'b1;
               ph_d       = 2'd2;
            end else if (tx_hs) begin
               tx_valid_d = 1'b0;
               ph_d       = 2'd0;
               if (o_mem_rd_addr == LAST_MEM) begin
                  state_d    = o_halted ? S_DONE : S_IDLE;
                  mem_addr_d = '0;
               end else begin
                  mem_addr_d = o_mem_rd_addr + NB_MEM_ADDR'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // The PC word is snapshotted straight into the tx register on dump entry.
      if (state_d == S_DUMP_PC && state_q != S_DUMP_PC) begin
         tx_valid_d = 1'b1;
         tx_data_d  = i_pc;
      end
   end

   // State, counters and registered outputs; reset drops any in-flight word.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q       <= S_IDLE;
         cyc_q         <= '0;
         drain_q       <= '0;
         ph_q          <= '0;
         o_cmd_ready   <= 1'b0;
         o_pipe_enable <= 1'b0;
         o_rf_rd_addr  <= '0;
         o_mem_rd_addr <= '0;
         o_tx_valid    <= 1'b0;
         o_tx_data     <= '0;
         o_halted      <= 1'b0;
         o_busy        <= 1'b0;
         o_timeout     <= 1'b0;
`ifdef PIPE_RUN_WATCHDOG_EN
         run_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         cyc_q         <= cyc_d;
         drain_q       <= drain_d;
         ph_q          <= ph_d;
         o_cmd_ready   <= (state_d == S_IDLE || state_d == S_DONE) && !cmd_hs;
         o_pipe_enable <= (state_d == S_RUN || state_d == S_STEP || state_d == S_DRAIN);
         o_rf_rd_addr  <= rf_addr_d;
         o_mem_rd_addr <= mem_addr_d;
         o_tx_valid    <= tx_valid_d;
         o_tx_data     <= tx_data_d;
         o_halted      <= halted_d;
         o_busy        <= !(state_d == S_IDLE || state_d == S_DONE);
         o_timeout     <= timeout_d;
`ifdef PIPE_RUN_WATCHDOG_EN
         run_q         <= run_d;
`endif
      end
   end

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Bench for pipeline_run_controller: register-file/memory models with 1-cycle
// read latency, a PC model that advances on enabled cycles, and a dump
// scoreboard fed with the expected words when each command is issued.
module tb_pipeline_run_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_cmd_valid = 1'b0;
   logic [7:0]  i_cmd = 8'h00;
   logic        o_cmd_ready;
   logic        i_halt = 1'b0;
   logic [31:0] i_pc = 32'h0;
   logic        o_pipe_enable;
   logic [4:0]  o_rf_rd_addr;
   logic [31:0] i_rf_rd_data = 32'h0;
   logic [4:0]  o_mem_rd_addr;
   logic [31:0] i_mem_rd_data = 32'h0;
   logic        o_tx_valid;
   logic [31:0] o_tx_data;
   logic        i_tx_ready = 1'b1;
   logic        o_halted;
   logic        o_busy;
   logic        o_timeout;

   always #5 clk = ~clk;

   pipeline_run_controller dut (
      .i_clock       (clk),
      .i_reset       (rst_n),
      .i_cmd_valid   (i_cmd_valid),
      .i_cmd         (i_cmd),
      .o_cmd_ready   (o_cmd_ready),
      .i_halt        (i_halt),
      .i_pc          (i_pc),
      .o_pipe_enable (o_pipe_enable),
      .o_rf_rd_addr  (o_rf_rd_addr),
      .i_rf_rd_data  (i_rf_rd_data),
      .o_mem_rd_addr (o_mem_rd_addr),
      .i_mem_rd_data (i_mem_rd_data),
      .o_tx_valid    (o_tx_valid),
      .o_tx_data     (o_tx_data),
      .i_tx_ready    (i_tx_ready),
      .o_halted      (o_halted),
      .o_busy        (o_busy),
      .o_timeout     (o_timeout)
   );

   int          n_tests = 0;
   int          n_fail = 0;
   int          en_cnt = 0;
   int          n_words = 0;
   int          ready_mode = 0;   // 0 always ready, 1 random, 2 held low
   logic [31:0] exp_q[$];
   logic [31:0] rf_m[32];
   logic [31:0] mem_m[32];
   logic [31:0] cyc_m = 32'h0;
   logic        stall_prev = 1'b0;
   logic [31:0] prev_data = 32'h0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Register file and data memory debug ports, registered read.
   always @(posedge clk) begin
      i_rf_rd_data  <= rf_m[o_rf_rd_addr];
      i_mem_rd_data <= mem_m[o_mem_rd_addr];
   end

   // PC model and enable-cycle counter.
   always @(negedge clk) begin
      if (o_pipe_enable) begin
         en_cnt++;
         i_pc = i_pc + 32'd4;
      end
   end

   // Transmitter ready pattern.
   always @(posedge clk) begin
      #1;
      if (ready_mode == 1)      i_tx_ready = ($urandom_range(0, 1) == 1);
      else if (ready_mode == 2) i_tx_ready = 1'b0;
      else                      i_tx_ready = 1'b1;
   end

   // Dump monitor: stall stability and in-order scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_valid_held", o_tx_valid, 1'b1);
            chk("stall_data_held", o_tx_data, prev_data);
         end
         if (o_tx_valid && i_tx_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 32'(exp_q.size()), 32'd1);
            end else begin
               chk($sformatf("dump_word%0d", n_words), o_tx_data, exp_q.pop_front());
               n_words++;
            end
         end
         stall_prev = o_tx_valid && !i_tx_ready;
         prev_data  = o_tx_data;
      end
   end

   task automatic push_dump(input logic [31:0] pc, input logic [31:0] cyc);
      exp_q.push_back(pc);
      exp_q.push_back(cyc);
      for (int i = 0; i < 32; i++) exp_q.push_back(rf_m[i]);
      for (int i = 0; i < 32; i++) exp_q.push_back(mem_m[i]);
   endtask

   task automatic send_cmd(input logic [7:0] c);
      int k;
      @(negedge clk);
      i_cmd_valid = 1'b1;
      i_cmd       = c;
      k = 0;
      while (!o_cmd_ready && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("cmd_accept", o_cmd_ready, 1'b1);
      @(posedge clk);
      #1;
      i_cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || o_busy) && k < 4000) begin
         @(negedge clk);
         k++;
      end
      chk("dump_complete", 32'((exp_q.size() == 0) && !o_busy), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 exp_q.delete();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      chk("global_timeout", 32'd1, 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      int base;
      int k;
      int nw0;
      for (int i = 0; i < 32; i++) begin
         rf_m[i]  = 32'h1000_0000 + 32'(i) * 32'h0000_0101;
         mem_m[i] = $urandom;
      end

      // Reset values.
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", o_cmd_ready, 1'b0);
      chk("rst_pipe_enable", o_pipe_enable, 1'b0);
      chk("rst_tx_valid", o_tx_valid, 1'b0);
      chk("rst_tx_data", o_tx_data, 32'h0);
      chk("rst_halted", o_halted, 1'b0);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_timeout", o_timeout, 1'b0);
      chk("rst_rf_addr", 32'(o_rf_rd_addr), 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_release", o_cmd_ready, 1'b1);

      // Plain dump from reset.
      base = en_cnt;
      push_dump(i_pc, cyc_m);
      send_cmd(8'h44);
      wait_idle();
      chk("dump_no_enable", 32'(en_cnt - base), 32'd0);
      chk("dump_idle_ready", o_cmd_ready, 1'b1);
      chk("dump_not_halted", o_halted, 1'b0);

      // Three single steps.
      for (int s = 0; s < 3; s++) begin
         base  = en_cnt;
         cyc_m = cyc_m + 32'd1;
         push_dump(i_pc + 32'd4, cyc_m);
         send_cmd(8'h53);
         wait_idle();
         chk("step_one_pulse", 32'(en_cnt - base), 32'd1);
      end

      // Run to HALT after 10 enabled cycles, then drain.
      do_reset();
      cyc_m = 32'd13;
      base  = en_cnt;
      push_dump(i_pc + 32'd52, cyc_m);
      send_cmd(8'h43);
      k = 0;
      while ((en_cnt - base) < 10 && k < 200) begin
         @(negedge clk);
         #1;
         k++;
      end
      i_halt = 1'b1;
      @(posedge clk);
      #1;
      i_halt = 1'b0;
      wait_idle();
      chk("run_enable_cycles", 32'(en_cnt - base), 32'd13);
      chk("run_halted", o_halted, 1'b1);
      chk("done_ready", o_cmd_ready, 1'b1);
      chk("run_timeout_low", o_timeout, 1'b0);

      // DONE ignores run/step.
      base = en_cnt;
      send_cmd(8'h43);
      repeat (10) @(negedge clk);
      send_cmd(8'h53);
      repeat (10) @(negedge clk);
      chk("done_ignores_run", 32'(en_cnt - base), 32'd0);
      chk("done_not_busy", o_busy, 1'b0);

      // Re-dump from DONE with a random ready pattern.
      ready_mode = 1;
      push_dump(i_pc, cyc_m);
      send_cmd(8'h44);
      wait_idle();
      ready_mode = 0;
      chk("redump_halted", o_halted, 1'b1);
      chk("redump_done_ready", o_cmd_ready, 1'b1);

      // Cycle counter wrap.
      do_reset();
      chk("reset_clears_halted", o_halted, 1'b0);
      @(negedge clk);
      dut.cyc_q = 32'hFFFF_FFFF;
      cyc_m = 32'h0;
      push_dump(i_pc + 32'd4, cyc_m);
      send_cmd(8'h53);
      wait_idle();

      // Reset while register word 7 is on the link.
      push_dump(i_pc, cyc_m);
      nw0 = n_words;
      send_cmd(8'h44);
      k = 0;
      while ((n_words - nw0) < 9 && k < 2000) begin
         @(negedge clk);
         #1;
         k++;
      end
      ready_mode = 2;
      k = 0;
      while (!(o_tx_valid && !i_tx_ready) && k < 50) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("inflight_reg7", o_tx_data, rf_m[7]);
      #1 rst_n = 1'b0;
      #1;
      chk("midreset_tx_valid", o_tx_valid, 1'b0);
      chk("midreset_pipe_enable", o_pipe_enable, 1'b0);
      chk("midreset_busy", o_busy, 1'b0);
      exp_q.delete();
      ready_mode = 0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc_m = 32'h0;
      push_dump(i_pc, cyc_m);
      send_cmd(8'h44);
      wait_idle();
      chk("post_reset_idle", o_cmd_ready, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
